// File: rtl/demultiplexor_buf_pkg.sv
// Shared definitions for the 1-to-2 registered demultiplexor: channel indices,
// default widths and the per-channel slot state type.
package demultiplexor_buf_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Defaults shared with the matching 2:1 multiplexor and its benches.
    localparam int DEFAULT_WIDTH     = 5;
    localparam int DEFAULT_CNT_WIDTH = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demultiplexor_buf_if.sv
// Producer/consumer bundle of the demultiplexor; the design side uses the
// slave modport, the bench drives through the master modport.
interface demultiplexor_buf_if
    import demultiplexor_buf_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic                 sel;
    logic [WIDTH-1:0]     din;
    logic                 out0_valid;
    logic                 out0_ready;
    logic [WIDTH-1:0]     out0_data;
    logic                 out1_valid;
    logic                 out1_ready;
    logic [WIDTH-1:0]     out1_data;
    logic [CNT_WIDTH-1:0] cnt0;
    logic [CNT_WIDTH-1:0] cnt1;

    modport slave (
        input  in_valid, sel, din, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

    modport master (
        output in_valid, sel, din, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

endinterface

// File: rtl/demultiplexor_buf_slot.sv
// One-entry output slot: EMPTY/FULL state, held data word and a wrapping
// count of every word loaded into it.
module demux_slot
    import demultiplexor_buf_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     din,
    input  logic                 ready,
    output logic                 valid,
    output logic [WIDTH-1:0]     data,
    output logic [CNT_WIDTH-1:0] cnt
);

    slot_state_e state;

    // A load always wins over a drain, so drain+load keeps the slot FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            data  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: if (load) state <= SLOT_FULL;
                SLOT_FULL:  if (ready && !load) state <= SLOT_EMPTY;
                default:    state <= SLOT_EMPTY;
            endcase
            if (load) begin
                data <= din;
                cnt  <= cnt + 1'b1;
            end
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demultiplexor_buf.sv
// Registered 1-to-2 demultiplexor: routes each accepted word into the slot
// picked by sel; a stalled slot only blocks words aimed at it.
module demultiplexor_buf
    import demultiplexor_buf_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    demultiplexor_buf_if.slave bus
);

    logic load0;
    logic load1;

    // Readiness looks only at the selected slot: empty, or draining this cycle.
    assign bus.in_ready = (bus.sel == CH0) ? (!bus.out0_valid || bus.out0_ready)
                                           : (!bus.out1_valid || bus.out1_ready);

    assign load0 = bus.in_valid && bus.in_ready && (bus.sel == CH0);
    assign load1 = bus.in_valid && bus.in_ready && (bus.sel == CH1);

    demux_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot0 (
        .clk   (clk),
        .rst   (rst),
        .load  (load0),
        .din   (bus.din),
        .ready (bus.out0_ready),
        .valid (bus.out0_valid),
        .data  (bus.out0_data),
        .cnt   (bus.cnt0)
    );

    demux_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot1 (
        .clk   (clk),
        .rst   (rst),
        .load  (load1),
        .din   (bus.din),
        .ready (bus.out1_ready),
        .valid (bus.out1_valid),
        .data  (bus.out1_data),
        .cnt   (bus.cnt1)
    );

endmodule

// File: tb/tb_demultiplexor_buf.sv
// Self-checking bench for demultiplexor_buf: a queue-based model checked every
// cycle plus directed vectors with hand-computed literal expectations.
module tb_demultiplexor_buf;

    localparam int W  = 5;
    localparam int CW = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    demultiplexor_buf_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    demultiplexor_buf #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel is a queue of words waiting for its consumer.
    logic [W-1:0]  mq0[$];
    logic [W-1:0]  mq1[$];
    logic [W-1:0]  md0, md1;
    logic [CW-1:0] mc0, mc1;
    bit            m_live;
    bit            prev_stall;
    logic          prev_sel;
    logic [W-1:0]  prev_din;

    function automatic bit m_ready(input logic s);
        if (s) return (mq1.size() == 0) || bus.out1_ready;
        return (mq0.size() == 0) || bus.out0_ready;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            mq0.delete();
            mq1.delete();
            md0 = '0; md1 = '0;
            mc0 = '0; mc1 = '0;
            m_live = 1'b1;
            prev_stall = 1'b0;
        end else if (m_live) begin
            if (prev_stall) begin
                tests++;
                if (!bus.in_valid || bus.sel !== prev_sel || bus.din !== prev_din) begin
                    fails++;
                    $display("[TB] FAIL producer_protocol: stalled word changed or withdrawn at %0t", $time);
                end
            end
            acc        = bus.in_valid && m_ready(bus.sel);
            prev_stall = bus.in_valid && !acc;
            prev_sel   = bus.sel;
            prev_din   = bus.din;
            if (mq0.size() != 0 && bus.out0_ready) void'(mq0.pop_front());
            if (mq1.size() != 0 && bus.out1_ready) void'(mq1.pop_front());
            if (acc) begin
                if (bus.sel) begin
                    mq1.push_back(bus.din); md1 = bus.din; mc1 = mc1 + 8'd1;
                end else begin
                    mq0.push_back(bus.din); md0 = bus.din; mc0 = mc0 + 8'd1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check_output("in_ready",   {31'd0, bus.in_ready},   {31'd0, m_ready(bus.sel)});
            check_output("out0_valid", {31'd0, bus.out0_valid}, {31'd0, mq0.size() != 0});
            check_output("out1_valid", {31'd0, bus.out1_valid}, {31'd0, mq1.size() != 0});
            check_output("out0_data",  {27'd0, bus.out0_data},  {27'd0, (mq0.size() != 0) ? mq0[0] : md0});
            check_output("out1_data",  {27'd0, bus.out1_data},  {27'd0, (mq1.size() != 0) ? mq1[0] : md1});
            check_output("cnt0",       {24'd0, bus.cnt0},       {24'd0, mc0});
            check_output("cnt1",       {24'd0, bus.cnt1},       {24'd0, mc1});
        end
    end

    // Present inputs just after an edge, then let one edge consume them.
    task automatic apply_stimulus(input logic v, input logic s, input logic [W-1:0] d);
        bus.in_valid = v;
        bus.sel      = s;
        bus.din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 5'h00);
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_live = 1'b0;
        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.sel        = 1'b0;
        bus.din        = '0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;

        // Reset then idle.
        repeat (2) apply_stimulus(1'b0, 1'b0, 5'h00);
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 5'h00);
        check_output("rst_out0_valid", {31'd0, bus.out0_valid}, 32'd0);
        check_output("rst_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        check_output("rst_out0_data",  {27'd0, bus.out0_data},  32'h00);
        check_output("rst_out1_data",  {27'd0, bus.out1_data},  32'h00);
        check_output("rst_cnt0",       {24'd0, bus.cnt0},       32'd0);
        check_output("rst_cnt1",       {24'd0, bus.cnt1},       32'd0);

        // Basic routing with both consumers ready.
        apply_stimulus(1'b1, 1'b0, 5'h15);
        check_output("route0a_valid",  {31'd0, bus.out0_valid}, 32'd1);
        check_output("route0a_data",   {27'd0, bus.out0_data},  32'h15);
        check_output("route0a_other",  {31'd0, bus.out1_valid}, 32'd0);
        apply_stimulus(1'b1, 1'b0, 5'h0A);
        check_output("route0b_data",   {27'd0, bus.out0_data},  32'h0A);
        check_output("route0b_other",  {31'd0, bus.out1_valid}, 32'd0);
        apply_stimulus(1'b1, 1'b1, 5'h15);
        check_output("route1a_valid",  {31'd0, bus.out1_valid}, 32'd1);
        check_output("route1a_data",   {27'd0, bus.out1_data},  32'h15);
        check_output("route1a_other",  {31'd0, bus.out0_valid}, 32'd0);
        apply_stimulus(1'b1, 1'b1, 5'h0A);
        check_output("route1b_data",   {27'd0, bus.out1_data},  32'h0A);
        apply_stimulus(1'b0, 1'b0, 5'h00);
        check_output("route_cnt0",     {24'd0, bus.cnt0},       32'd2);
        check_output("route_cnt1",     {24'd0, bus.cnt1},       32'd2);

        // Backpressure on channel 0 must not block channel 1.
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 5'h15);
        bus.in_valid = 1'b0;
        bus.sel      = 1'b0;
        bus.din      = 5'h0A;
        #1;
        check_output("bp_stall_ready", {31'd0, bus.in_ready},   32'd0);
        @(posedge clk);
        #1;
        check_output("bp_hold_data",   {27'd0, bus.out0_data},  32'h15);
        check_output("bp_hold_valid",  {31'd0, bus.out0_valid}, 32'd1);
        bus.in_valid = 1'b1;
        bus.sel      = 1'b1;
        bus.din      = 5'h0A;
        #1;
        check_output("bp_other_ready", {31'd0, bus.in_ready},   32'd1);
        @(posedge clk);
        #1;
        check_output("bp_other_data",  {27'd0, bus.out1_data},  32'h0A);
        check_output("bp_still_data",  {27'd0, bus.out0_data},  32'h15);
        bus.out0_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 5'h0A);
        check_output("bp_release_data", {27'd0, bus.out0_data}, 32'h0A);
        check_output("bp_release_cnt0", {24'd0, bus.cnt0},      32'd4);
        check_output("bp_release_cnt1", {24'd0, bus.cnt1},      32'd3);
        apply_stimulus(1'b0, 1'b0, 5'h00);

        // Streaming on channel 1 with drain and load in the same cycle.
        pulse_reset();
        bus.out1_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            bus.in_valid = 1'b1;
            bus.sel      = 1'b1;
            bus.din      = W'(k);
            #1;
            check_output("stream_ready", {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check_output("stream_valid", {31'd0, bus.out1_valid}, 32'd1);
            check_output("stream_data",  {27'd0, bus.out1_data},  32'(k));
        end
        check_output("stream_cnt1", {24'd0, bus.cnt1}, 32'd6);
        apply_stimulus(1'b0, 1'b0, 5'h00);

        // Counter wrap on channel 0.
        bus.out0_ready = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            apply_stimulus(1'b1, 1'b0, W'(k));
            if (k == 255) check_output("wrap_cnt0_255", {24'd0, bus.cnt0}, 32'hFF);
            if (k == 256) check_output("wrap_cnt0_256", {24'd0, bus.cnt0}, 32'h00);
        end
        check_output("wrap_cnt1", {24'd0, bus.cnt1}, 32'd6);
        apply_stimulus(1'b0, 1'b0, 5'h00);

        // Reset with both slots holding undelivered words.
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 5'h11);
        apply_stimulus(1'b1, 1'b1, 5'h12);
        check_output("mid_full0", {31'd0, bus.out0_valid}, 32'd1);
        check_output("mid_full1", {31'd0, bus.out1_valid}, 32'd1);
        pulse_reset();
        check_output("mid_valid0", {31'd0, bus.out0_valid}, 32'd0);
        check_output("mid_valid1", {31'd0, bus.out1_valid}, 32'd0);
        check_output("mid_data0",  {27'd0, bus.out0_data},  32'h00);
        check_output("mid_data1",  {27'd0, bus.out1_data},  32'h00);
        check_output("mid_cnt0",   {24'd0, bus.cnt0},       32'd0);
        check_output("mid_cnt1",   {24'd0, bus.cnt1},       32'd0);
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        repeat (3) begin
            apply_stimulus(1'b0, 1'b0, 5'h00);
            check_output("mid_no_emit0", {31'd0, bus.out0_valid}, 32'd0);
            check_output("mid_no_emit1", {31'd0, bus.out1_valid}, 32'd0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
